// File: rtl/row_col_cod_nxn_slew.sv
// N x N row/column thermometer encoder for the DCO capacitor array, with a
// slew-limited applied word, target clamping and busy/saturation flags.
module row_col_cod_nxn_slew #(
  parameter int SIZE     = 5,
  parameter int WW       = $clog2(SIZE*SIZE+1),
  parameter int MAX_STEP = 0,
  parameter int RST_WORD = 13
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [WW-1:0]   word,
  output logic [SIZE-1:0] r_all_n,
  output logic [SIZE-1:0] row,
  output logic [SIZE-1:0] col,
  output logic [WW-1:0]   cur_word,
  output logic            busy,
  output logic            sat
);

  localparam int FULL = SIZE * SIZE;

  // Returns {r_all_n, row, col} for applied code w; odd rows fill from the top bit.
  function automatic logic [3*SIZE-1:0] decode(input logic [WW-1:0] w);
    int              wi;
    int              ri;
    int              cc;
    logic [SIZE-1:0] ran;
    logic [SIZE-1:0] rw;
    logic [SIZE-1:0] cl;
    wi = int'(w);
    ri = 0;
    // Compare chain instead of a divider: ri counts completed rows below w.
    for (int i = 1; i < SIZE; i++) begin
      if (wi > i * SIZE) ri++;
    end
    cc = wi - ri * SIZE;
    for (int j = 0; j < SIZE; j++) begin
      ran[j] = (j >= ri);
      rw[j]  = (j == ri);
      cl[j]  = ri[0] ? (j >= SIZE - cc) : (j < cc);
    end
    return {ran, rw, cl};
  endfunction

  logic [WW-1:0] cur_next;
  logic [WW-1:0] tgt;
  logic          sat_next;

  always_comb begin
    int cur_i;
    int tgt_i;
    int diff;
    int nxt_i;
    // NOTE: every always_comb output is assigned up front so no path can infer a latch.
    cur_i    = int'(cur_word);
    tgt_i    = (int'(word) > FULL) ? FULL : int'(word);
    sat_next = (int'(word) > FULL);
    diff     = tgt_i - cur_i;
    nxt_i    = tgt_i;
    // Signed difference keeps the step from ever wrapping past 0 or FULL.
    if (MAX_STEP != 0 && (diff > MAX_STEP || diff < -MAX_STEP)) begin
      nxt_i = (diff > 0) ? cur_i + MAX_STEP : cur_i - MAX_STEP;
    end
    cur_next = WW'(nxt_i);
    tgt      = WW'(tgt_i);
  end

  // Falling-edge state; outputs are decoded from cur_next so they always match cur_word.
  always_ff @(negedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers sample together.
    if (rst) begin
      cur_word              <= WW'(RST_WORD);
      {r_all_n, row, col}   <= decode(WW'(RST_WORD));
      busy                  <= 1'b0;
      sat                   <= 1'b0;
    end else if (en) begin
      cur_word              <= cur_next;
      {r_all_n, row, col}   <= decode(cur_next);
      busy                  <= (cur_next != tgt);
      sat                   <= sat_next;
    end
  end

endmodule

// File: tb/tb_row_col_cod_nxn_slew.sv
// Directed and model-based checks of row_col_cod_nxn_slew at SIZE=5 with
// MAX_STEP = 0, 1, 3 and 4 instances sharing the same stimulus.
module tb_row_col_cod_nxn_slew;

  logic       clk;
  logic       rst;
  logic       en;
  logic [4:0] word;

  logic [4:0] ran0, row0, col0, cw0;  logic busy0, sat0;
  logic [4:0] ran1, row1, col1, cw1;  logic busy1, sat1;
  logic [4:0] ran3, row3, col3, cw3;  logic busy3, sat3;
  logic [4:0] ran4, row4, col4, cw4;  logic busy4, sat4;

  int checks = 0;
  int errors = 0;

  row_col_cod_nxn_slew #(.SIZE(5), .MAX_STEP(0)) u0 (
    .clk(clk), .rst(rst), .en(en), .word(word), .r_all_n(ran0), .row(row0),
    .col(col0), .cur_word(cw0), .busy(busy0), .sat(sat0));
  row_col_cod_nxn_slew #(.SIZE(5), .MAX_STEP(1)) u1 (
    .clk(clk), .rst(rst), .en(en), .word(word), .r_all_n(ran1), .row(row1),
    .col(col1), .cur_word(cw1), .busy(busy1), .sat(sat1));
  row_col_cod_nxn_slew #(.SIZE(5), .MAX_STEP(3)) u3 (
    .clk(clk), .rst(rst), .en(en), .word(word), .r_all_n(ran3), .row(row3),
    .col(col3), .cur_word(cw3), .busy(busy3), .sat(sat3));
  row_col_cod_nxn_slew #(.SIZE(5), .MAX_STEP(4)) u4 (
    .clk(clk), .rst(rst), .en(en), .word(word), .r_all_n(ran4), .row(row4),
    .col(col4), .cur_word(cw4), .busy(busy4), .sat(sat4));

  // {r_all_n, row, col, cur_word, busy, sat}
  wire [21:0] pk0 = {ran0, row0, col0, cw0, busy0, sat0};
  wire [21:0] pk1 = {ran1, row1, col1, cw1, busy1, sat1};
  wire [21:0] pk3 = {ran3, row3, col3, cw3, busy3, sat3};
  wire [21:0] pk4 = {ran4, row4, col4, cw4, busy4, sat4};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One falling (active) edge, then return to the rising edge to sample and drive.
  task automatic tick();
    @(negedge clk);
    @(posedge clk);
  endtask

  function automatic logic [14:0] ref_dec(input int w);
    int ri, cc;
    logic [4:0] m, c;
    ri = (w == 0) ? 0 : (w - 1) / 5;
    cc = w - ri * 5;
    m  = 5'((1 << cc) - 1);
    c  = (ri % 2 == 0) ? m : 5'(m << (5 - cc));
    return {5'(~((1 << ri) - 1)), 5'(1 << ri), c};
  endfunction

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; word = 5'd0;
    tick();
    checks++;
    if (pk0 !== {5'b11100, 5'b00100, 5'b00111, 5'd13, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset: got %b required %b", pk0,
               {5'b11100, 5'b00100, 5'b00111, 5'd13, 1'b0, 1'b0});
    end
    rst = 1'b0;
  endtask

  task automatic test_decode();
    logic [19:0] vec [5];
    vec[0] = {5'd0,  5'b11111, 5'b00001, 5'b00000};
    vec[1] = {5'd5,  5'b11111, 5'b00001, 5'b11111};
    vec[2] = {5'd6,  5'b11110, 5'b00010, 5'b10000};
    vec[3] = {5'd10, 5'b11110, 5'b00010, 5'b11111};
    vec[4] = {5'd25, 5'b10000, 5'b10000, 5'b11111};
    en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      word = vec[i][19:15];
      tick();
      checks++;
      if (pk0 !== {vec[i][14:0], vec[i][19:15], 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL decode w=%0d: got %b required %b", vec[i][19:15], pk0,
                 {vec[i][14:0], vec[i][19:15], 1'b0, 1'b0});
      end
    end
  endtask

  task automatic test_clamp();
    en = 1'b1; word = 5'd30;
    tick();
    checks++;
    if (pk0 !== {5'b10000, 5'b10000, 5'b11111, 5'd25, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL clamp30: got %b required %b", pk0,
               {5'b10000, 5'b10000, 5'b11111, 5'd25, 1'b0, 1'b1});
    end
    word = 5'd24;
    tick();
    checks++;
    if (pk0 !== {5'b10000, 5'b10000, 5'b01111, 5'd24, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL clamp24: got %b required %b", pk0,
               {5'b10000, 5'b10000, 5'b01111, 5'd24, 1'b0, 1'b0});
    end
  endtask

  task automatic test_slew();
    logic [4:0] exp_cw [3];
    logic       exp_bz [3];
    exp_cw[0] = 5'd17; exp_cw[1] = 5'd21; exp_cw[2] = 5'd25;
    exp_bz[0] = 1'b1;  exp_bz[1] = 1'b1;  exp_bz[2] = 1'b0;
    rst = 1'b1; tick(); rst = 1'b0;
    en = 1'b1; word = 5'd25;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (cw4 !== exp_cw[i] || busy4 !== exp_bz[i]) begin
        errors++;
        $display("FAIL slew step%0d: got cur=%0d busy=%b required cur=%0d busy=%b",
                 i, cw4, busy4, exp_cw[i], exp_bz[i]);
      end
      if (i == 0) begin
        checks++;
        if ({ran4, row4, col4} !== {5'b11000, 5'b01000, 5'b11000}) begin
          errors++;
          $display("FAIL slew decode17: got %b required %b", {ran4, row4, col4},
                   {5'b11000, 5'b01000, 5'b11000});
        end
      end
    end
  endtask

  task automatic test_freeze_redirect();
    rst = 1'b1; tick(); rst = 1'b0;
    en = 1'b1; word = 5'd25;
    tick();
    en = 1'b0;
    tick();
    tick();
    checks++;
    if (cw4 !== 5'd17 || busy4 !== 1'b1) begin
      errors++;
      $display("FAIL freeze: got cur=%0d busy=%b required cur=17 busy=1", cw4, busy4);
    end
    en = 1'b1; word = 5'd15;
    tick();
    checks++;
    if (cw4 !== 5'd15 || busy4 !== 1'b0) begin
      errors++;
      $display("FAIL redirect: got cur=%0d busy=%b required cur=15 busy=0", cw4, busy4);
    end
  endtask

  task automatic test_reset_mid_slew();
    rst = 1'b1; tick(); rst = 1'b0;
    en = 1'b1; word = 5'd25;
    tick();
    checks++;
    if (busy4 !== 1'b1) begin
      errors++;
      $display("FAIL midslew busy: got %b required 1", busy4);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (pk4 !== {5'b11100, 5'b00100, 5'b00111, 5'd13, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL midslew reset: got %b required %b", pk4,
               {5'b11100, 5'b00100, 5'b00111, 5'd13, 1'b0, 1'b0});
    end
  endtask

  task automatic test_random();
    int ms [3];
    int cur [3];
    int bz [3];
    int st [3];
    int tgt, d;
    logic [21:0] got, exp;
    ms[0] = 0; ms[1] = 1; ms[2] = 3;
    rst = 1'b1; tick();
    for (int k = 0; k < 3; k++) begin cur[k] = 13; bz[k] = 0; st[k] = 0; end
    for (int n = 0; n < 400; n++) begin
      rst  = ($urandom_range(0, 19) == 0);
      en   = ($urandom_range(0, 3) != 0);
      word = 5'($urandom_range(0, 31));
      tick();
      tgt = (int'(word) > 25) ? 25 : int'(word);
      for (int k = 0; k < 3; k++) begin
        if (rst) begin
          cur[k] = 13; bz[k] = 0; st[k] = 0;
        end else if (en) begin
          d = tgt - cur[k];
          if (ms[k] == 0 || (d <= ms[k] && d >= -ms[k])) cur[k] = tgt;
          else if (d > 0) cur[k] = cur[k] + ms[k];
          else cur[k] = cur[k] - ms[k];
          bz[k] = (cur[k] != tgt);
          st[k] = (int'(word) > 25);
        end
        got = (k == 0) ? pk0 : (k == 1) ? pk1 : pk3;
        exp = {ref_dec(cur[k]), 5'(cur[k]), 1'(bz[k]), 1'(st[k])};
        checks++;
        if (got !== exp) begin
          errors++;
          $display("FAIL random ms=%0d cyc=%0d: got %b required %b", ms[k], n, got, exp);
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; word = 5'd0;
    @(posedge clk);
    test_reset();
    test_decode();
    test_clamp();
    test_slew();
    test_freeze_redirect();
    test_reset_mid_slew();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
